// File: rtl/lcd_char_writer_pkg.sv
// Shared types, opcodes and default timings for the character-LCD writer.
// The CPU side reuses the opcode values for its LCD instruction encoding.
package lcd_char_writer_pkg;

    localparam int unsigned TIMER_W = 20;
    localparam int unsigned STEP_W  = 3;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned BYTE_W  = 8;

    localparam int unsigned DEF_T_POWERUP = 750000;
    localparam int unsigned DEF_T_INIT1   = 205000;
    localparam int unsigned DEF_T_INIT2   = 5000;
    localparam int unsigned DEF_T_CMD     = 2000;
    localparam int unsigned DEF_T_CLEAR   = 82000;
    localparam int unsigned DEF_T_GAP     = 50;
    localparam int unsigned DEF_T_EPULSE  = 12;

    localparam logic [BYTE_W-1:0] OP_FUNC_SET   = 8'h28;
    localparam logic [BYTE_W-1:0] OP_ENTRY_MODE = 8'h06;
    localparam logic [BYTE_W-1:0] OP_DISP_ON    = 8'h0C;
    localparam logic [BYTE_W-1:0] OP_CLEAR      = 8'h01;
    localparam logic [BYTE_W-1:0] OP_HOME       = 8'h02;

    localparam logic [NIB_W-1:0] NIB_WAKE  = 4'h3;
    localparam logic [NIB_W-1:0] NIB_4BIT  = 4'h2;

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_INIT,
        S_CFG,
        S_IDLE,
        S_WR_HI,
        S_GAP,
        S_WR_LO,
        S_POST
    } state_t;

    // Sub-phase of a nibble write; P_WAIT is the inter-nibble wait inside S_INIT.
    typedef enum logic [1:0] {
        P_SETUP,
        P_PULSE,
        P_HOLD,
        P_WAIT
    } phase_t;

    typedef struct packed {
        logic                is_command;
        logic [BYTE_W-1:0]   data;
    } lcd_req_t;

    function automatic logic [BYTE_W-1:0] cfg_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return OP_FUNC_SET;
            2'd1:    return OP_ENTRY_MODE;
            2'd2:    return OP_DISP_ON;
            default: return OP_CLEAR;
        endcase
    endfunction

    // Clear and Return Home need the long execution wait.
    function automatic logic is_slow_cmd(input lcd_req_t req);
        return req.is_command && (req.data == OP_CLEAR || req.data == OP_HOME);
    endfunction

endpackage

// File: rtl/lcd_char_writer_if.sv
// CPU-side write handshake into the LCD writer.
interface lcd_char_writer_if;
    import lcd_char_writer_pkg::*;

    logic     write;
    lcd_req_t req;
    logic     ready;

    modport master (output write, output req, input ready);
    modport slave  (input write, input req, output ready);

endinterface

// File: rtl/lcd_delay_timer.sv
// Down-counter shared by every wait and nibble phase; done while it reads zero.
module lcd_delay_timer
    import lcd_char_writer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               done_c
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign done_c = (count == '0);

endmodule

// File: rtl/lcd_char_writer.sv
// HD44780 4-bit writer: autonomous power-on init and config, then one byte
// per accepted CPU request, each split into two timed nibble writes.
module lcd_char_writer
    import lcd_char_writer_pkg::*;
#(
    parameter int unsigned T_POWERUP = DEF_T_POWERUP,
    parameter int unsigned T_INIT1   = DEF_T_INIT1,
    parameter int unsigned T_INIT2   = DEF_T_INIT2,
    parameter int unsigned T_CMD     = DEF_T_CMD,
    parameter int unsigned T_CLEAR   = DEF_T_CLEAR,
    parameter int unsigned T_GAP     = DEF_T_GAP,
    parameter int unsigned T_EPULSE  = DEF_T_EPULSE
) (
    input  logic               clk,
    input  logic               rst,
    lcd_char_writer_if.slave   bus,
    output logic               lcd_e,
    output logic               lcd_rs,
    output logic               lcd_rw,
    output logic               sf_ce0,
    output logic [NIB_W-1:0]   lcd_data
);

    // Power-up spends one cycle loading the timer, hence N-2.
    localparam logic [TIMER_W-1:0] LD_POWERUP = TIMER_W'(T_POWERUP - 2);
    localparam logic [TIMER_W-1:0] LD_INIT1   = TIMER_W'(T_INIT1 - 1);
    localparam logic [TIMER_W-1:0] LD_INIT2   = TIMER_W'(T_INIT2 - 1);
    localparam logic [TIMER_W-1:0] LD_CMD     = TIMER_W'(T_CMD - 1);
    localparam logic [TIMER_W-1:0] LD_CLEAR   = TIMER_W'(T_CLEAR - 1);
    localparam logic [TIMER_W-1:0] LD_GAP     = TIMER_W'(T_GAP - 1);
    localparam logic [TIMER_W-1:0] LD_EPULSE  = TIMER_W'(T_EPULSE - 1);
    localparam logic [TIMER_W-1:0] LD_SETUP   = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] LD_HOLD    = '0;

    state_t              state, state_d;
    phase_t              ph, ph_d;
    logic [STEP_W-1:0]   step, step_d;
    lcd_req_t            req_q, req_d;
    logic                armed, armed_d;
    logic                booting, booting_d;
    logic                ready, ready_d;
    logic                e_d, rs_d;
    logic [NIB_W-1:0]    data_d;

    logic                t_load;
    logic [TIMER_W-1:0]  t_val;
    logic                t_done_c;
    logic                accept_c, nw_c, nw_end_c;

    lcd_delay_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .done_c   (t_done_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_PWR_WAIT;
            ph       <= P_SETUP;
            step     <= '0;
            req_q    <= '0;
            armed    <= 1'b0;
            booting  <= 1'b1;
            ready    <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
        end else begin
            state    <= state_d;
            ph       <= ph_d;
            step     <= step_d;
            req_q    <= req_d;
            armed    <= armed_d;
            booting  <= booting_d;
            ready    <= ready_d;
            lcd_e    <= e_d;
            lcd_rs   <= rs_d;
            lcd_data <= data_d;
        end
    end

    always_comb begin
        state_d   = state;
        ph_d      = ph;
        step_d    = step;
        req_d     = req_q;
        armed_d   = armed;
        booting_d = booting;
        t_load    = 1'b0;
        t_val     = '0;

        accept_c = (state == S_IDLE) && ready && bus.write;
        nw_c     = (state == S_INIT && ph != P_WAIT) || state == S_WR_HI || state == S_WR_LO;
        nw_end_c = nw_c && ph == P_HOLD && t_done_c;

        if (!bus.write) begin
            armed_d = 1'b1;
        end

        // Setup -> E pulse -> hold sequencing common to every nibble write.
        if (nw_c && t_done_c) begin
            case (ph)
                P_SETUP: begin ph_d = P_PULSE; t_load = 1'b1; t_val = LD_EPULSE; end
                P_PULSE: begin ph_d = P_HOLD;  t_load = 1'b1; t_val = LD_HOLD;   end
                default: ;
            endcase
        end

        case (state)
            S_PWR_WAIT: begin
                if (ph == P_SETUP) begin
                    ph_d   = P_WAIT;
                    t_load = 1'b1;
                    t_val  = LD_POWERUP;
                end else if (t_done_c) begin
                    state_d = S_INIT;
                    ph_d    = P_SETUP;
                    t_load  = 1'b1;
                    t_val   = LD_SETUP;
                end
            end
            S_INIT: begin
                if (nw_end_c) begin
                    ph_d   = P_WAIT;
                    t_load = 1'b1;
                    case (step[1:0])
                        2'd0:    t_val = LD_INIT1;
                        2'd1:    t_val = LD_INIT2;
                        default: t_val = LD_CMD;
                    endcase
                end else if (ph == P_WAIT && t_done_c) begin
                    step_d = step + STEP_W'(1);
                    if (step == STEP_W'(3)) begin
                        state_d = S_CFG;
                    end else begin
                        ph_d   = P_SETUP;
                        t_load = 1'b1;
                        t_val  = LD_SETUP;
                    end
                end
            end
            S_CFG: begin
                req_d.is_command = 1'b1;
                req_d.data       = cfg_byte(step[1:0]);
                state_d          = S_WR_HI;
                ph_d             = P_SETUP;
                t_load           = 1'b1;
                t_val            = LD_SETUP;
            end
            S_IDLE: begin
                if (accept_c) begin
                    req_d   = bus.req;
                    armed_d = 1'b0;
                    state_d = S_WR_HI;
                    ph_d    = P_SETUP;
                    t_load  = 1'b1;
                    t_val   = LD_SETUP;
                end
            end
            S_WR_HI: begin
                if (nw_end_c) begin
                    state_d = S_GAP;
                    t_load  = 1'b1;
                    t_val   = LD_GAP;
                end
            end
            S_GAP: begin
                if (t_done_c) begin
                    state_d = S_WR_LO;
                    ph_d    = P_SETUP;
                    t_load  = 1'b1;
                    t_val   = LD_SETUP;
                end
            end
            S_WR_LO: begin
                if (nw_end_c) begin
                    state_d = S_POST;
                    t_load  = 1'b1;
                    t_val   = is_slow_cmd(req_q) ? LD_CLEAR : LD_CMD;
                end
            end
            S_POST: begin
                if (t_done_c) begin
                    if (booting && step != STEP_W'(7)) begin
                        step_d  = step + STEP_W'(1);
                        state_d = S_CFG;
                    end else begin
                        state_d = S_IDLE;
                        if (booting) begin
                            booting_d = 1'b0;
                            armed_d   = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_PWR_WAIT;
        endcase

        // Pin values follow the next state so they line up with it cycle for cycle.
        e_d    = 1'b0;
        rs_d   = lcd_rs;
        data_d = lcd_data;
        case (state_d)
            S_INIT: begin
                if (ph_d != P_WAIT) begin
                    rs_d   = 1'b0;
                    data_d = (step_d == STEP_W'(3)) ? NIB_4BIT : NIB_WAKE;
                    e_d    = (ph_d == P_PULSE);
                end
            end
            S_WR_HI: begin
                rs_d   = ~req_d.is_command;
                data_d = req_d.data[7:4];
                e_d    = (ph_d == P_PULSE);
            end
            S_WR_LO: begin
                rs_d   = ~req_d.is_command;
                data_d = req_d.data[3:0];
                e_d    = (ph_d == P_PULSE);
            end
            default: ;
        endcase

        ready_d = (state_d == S_IDLE) && armed_d;
    end

    assign bus.ready = ready;
    assign lcd_rw    = 1'b0;
    assign sf_ce0    = 1'b1;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Directed bench for lcd_char_writer with shortened timings.
module tb_lcd_char_writer;
    import lcd_char_writer_pkg::*;

    localparam int TP = 20, TI1 = 10, TI2 = 6, TC = 4, TCL = 8, TG = 3, TE = 2;
    localparam int NW = 3 + TE;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_e, lcd_rs, lcd_rw, sf_ce0;
    logic [3:0] lcd_data;

    lcd_char_writer_if bus ();

    lcd_char_writer #(
        .T_POWERUP (TP), .T_INIT1 (TI1), .T_INIT2 (TI2), .T_CMD (TC),
        .T_CLEAR (TCL), .T_GAP (TG), .T_EPULSE (TE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .sf_ce0   (sf_ce0),
        .lcd_data (lcd_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [3:0] nib;
        logic       rs;
        int         rise;
        int         width;
    } pulse_t;

    pulse_t pulses[$];
    pulse_t cur;
    logic       prev_e = 1'b0;
    logic       prev_rs = 1'b0;
    logic [3:0] prev_d = '0;

    // Pin monitor: records every E pulse and checks the static pins and E-high stability.
    always @(posedge clk) begin
        #1;
        check("rw_low", int'(lcd_rw), 0);
        check("ce0_high", int'(sf_ce0), 1);
        if (lcd_e && prev_e) begin
            check("data_stable_e", int'(lcd_data), int'(prev_d));
            check("rs_stable_e", int'(lcd_rs), int'(prev_rs));
        end
        if (lcd_e && !prev_e) begin
            cur.nib  = lcd_data;
            cur.rs   = lcd_rs;
            cur.rise = cyc;
        end
        if (!lcd_e && prev_e) begin
            cur.width = cyc - cur.rise;
            pulses.push_back(cur);
        end
        prev_e  = lcd_e;
        prev_rs = lcd_rs;
        prev_d  = lcd_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_and_boot(output int first, output int rdy_cyc);
        int n;
        n     = 0;
        first = 0;
        rst   = 1'b0;
        while (!bus.ready && n < 3000) begin
            tick();
            n++;
            if (lcd_e && first == 0) first = n;
        end
        check("boot_ready", int'(bus.ready), 1);
        rdy_cyc = cyc;
    endtask

    task automatic check_boot(input int base, input int first, input int rdy_cyc);
        logic [3:0] exp_nib [12];
        int         exp_gap [3];
        exp_nib = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
        exp_gap = '{NW + TI1, NW + TI2, NW + TC};
        check("boot_first_e", first, TP + 2);
        check("boot_pulses", pulses.size() - base, 12);
        if (pulses.size() - base == 12) begin
            for (int i = 0; i < 12; i++) begin
                check($sformatf("boot_nib%0d", i), int'(pulses[base+i].nib), int'(exp_nib[i]));
                check($sformatf("boot_rs%0d", i), int'(pulses[base+i].rs), 0);
                check($sformatf("boot_ew%0d", i), pulses[base+i].width, TE);
            end
            for (int i = 0; i < 3; i++) begin
                check($sformatf("init_gap%0d", i),
                      pulses[base+i+1].rise - pulses[base+i].rise, exp_gap[i]);
            end
            check("boot_ready_delay", rdy_cyc - pulses[base+11].rise, TE + 1 + TCL);
        end
    endtask

    // One-cycle write pulse; returns cycles to ready and to first E high.
    task automatic send_byte(input logic is_cmd, input logic [7:0] d,
                             output int lat, output int first_e);
        check("pre_ready", int'(bus.ready), 1);
        bus.write          = 1'b1;
        bus.req.is_command = is_cmd;
        bus.req.data       = d;
        tick();
        bus.write = 1'b0;
        lat       = 1;
        first_e   = 0;
        check("ready_drop", int'(bus.ready), 0);
        while (!bus.ready && lat < 500) begin
            tick();
            lat++;
            if (lcd_e && first_e == 0) first_e = lat;
        end
    endtask

    typedef struct {
        logic       is_cmd;
        logic [7:0] data;
        logic       exp_rs;
        logic [3:0] exp_hi;
        logic [3:0] exp_lo;
        int         exp_lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int first, rdy, base, lat, fe, n;

        vecs[0] = '{1'b0, 8'h41, 1'b1, 4'h4, 4'h1, 18};
        vecs[1] = '{1'b1, 8'h01, 1'b0, 4'h0, 4'h1, 22};
        vecs[2] = '{1'b0, 8'hA7, 1'b1, 4'hA, 4'h7, 18};
        vecs[3] = '{1'b1, 8'h02, 1'b0, 4'h0, 4'h2, 22};
        vecs[4] = '{1'b0, 8'h01, 1'b1, 4'h0, 4'h1, 18};
        vecs[5] = '{1'b1, 8'h80, 1'b0, 4'h8, 4'h0, 18};

        bus.write = 1'b0;
        bus.req   = '0;
        rst       = 1'b1;
        repeat (3) tick();
        check("rst_ready", int'(bus.ready), 0);
        check("rst_e", int'(lcd_e), 0);
        check("rst_rs", int'(lcd_rs), 0);
        check("rst_data", int'(lcd_data), 0);

        release_and_boot(first, rdy);
        check_boot(0, first, rdy);

        foreach (vecs[i]) begin
            base = pulses.size();
            send_byte(vecs[i].is_cmd, vecs[i].data, lat, fe);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_first_e", i), fe, 3);
            check($sformatf("v%0d_pulses", i), pulses.size() - base, 2);
            if (pulses.size() - base == 2) begin
                check($sformatf("v%0d_hi", i), int'(pulses[base].nib), int'(vecs[i].exp_hi));
                check($sformatf("v%0d_lo", i), int'(pulses[base+1].nib), int'(vecs[i].exp_lo));
                check($sformatf("v%0d_rs_hi", i), int'(pulses[base].rs), int'(vecs[i].exp_rs));
                check($sformatf("v%0d_rs_lo", i), int'(pulses[base+1].rs), int'(vecs[i].exp_rs));
                check($sformatf("v%0d_ew", i), pulses[base].width, TE);
                check($sformatf("v%0d_nib_gap", i), pulses[base+1].rise - pulses[base].rise, NW + TG);
            end
        end

        // Level held across completion sends a single byte.
        base               = pulses.size();
        bus.write          = 1'b1;
        bus.req.is_command = 1'b0;
        bus.req.data       = 8'h55;
        repeat (200) tick();
        check("hold_pulses", pulses.size() - base, 2);
        check("hold_ready", int'(bus.ready), 0);
        bus.write = 1'b0;
        tick();
        check("rearm_ready", int'(bus.ready), 1);
        send_byte(1'b0, 8'h55, lat, fe);
        check("rearm_latency", lat, 18);
        check("rearm_pulses", pulses.size() - base, 4);
        if (pulses.size() - base == 4) begin
            check("rearm_hi", int'(pulses[base+2].nib), 5);
        end

        // Request while busy is dropped.
        base               = pulses.size();
        bus.write          = 1'b1;
        bus.req.is_command = 1'b0;
        bus.req.data       = 8'h41;
        tick();
        bus.write = 1'b0;
        repeat (5) tick();
        check("busy_ready", int'(bus.ready), 0);
        bus.write          = 1'b1;
        bus.req.is_command = 1'b1;
        bus.req.data       = 8'hFF;
        tick();
        bus.write = 1'b0;
        n = 0;
        while (!bus.ready && n < 500) begin tick(); n++; end
        check("ign_ready", int'(bus.ready), 1);
        repeat (30) tick();
        check("ign_pulses", pulses.size() - base, 2);
        if (pulses.size() - base == 2) begin
            check("ign_hi", int'(pulses[base].nib), 4);
            check("ign_lo", int'(pulses[base+1].nib), 1);
            check("ign_rs", int'(pulses[base+1].rs), 1);
        end

        // Reset while the low nibble strobe is high.
        bus.write          = 1'b1;
        bus.req.is_command = 1'b0;
        bus.req.data       = 8'h41;
        tick();
        bus.write = 1'b0;
        repeat (10) tick();
        check("lo_e_high", int'(lcd_e), 1);
        check("lo_data", int'(lcd_data), 1);
        rst = 1'b1;
        tick();
        check("rst_mid_e", int'(lcd_e), 0);
        check("rst_mid_ready", int'(bus.ready), 0);
        repeat (2) tick();
        base = pulses.size();
        release_and_boot(first, rdy);
        check_boot(base, first, rdy);

        // Write held since reset is taken once after init.
        rst                = 1'b1;
        bus.write          = 1'b1;
        bus.req.is_command = 1'b0;
        bus.req.data       = 8'h33;
        repeat (2) tick();
        base = pulses.size();
        release_and_boot(first, rdy);
        check_boot(base, first, rdy);
        n = 0;
        while (pulses.size() - base < 14 && n < 200) begin tick(); n++; end
        repeat (30) tick();
        check("held_pulses", pulses.size() - base, 14);
        if (pulses.size() - base == 14) begin
            check("held_hi", int'(pulses[base+12].nib), 3);
            check("held_lo", int'(pulses[base+13].nib), 3);
            check("held_rs", int'(pulses[base+13].rs), 1);
        end
        check("held_ready", int'(bus.ready), 0);
        bus.write = 1'b0;
        tick();
        check("held_rearm", int'(bus.ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
